baby_ram_arbiter: RTL and testbench
===================================

BABY_RAM_ARBITER -- requirements
Module: baby_ram_arbiter

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state updates on its rising edge.
REQ-002 SHALL have ports: reset_ni  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: cpu_addr_i  in  5 / cpu_rw_en_i  in  1 (0 = read, 1 = write) / cpu_data_i  in  32: Baby core memory request.
REQ-004 SHALL have ports: cpu_data_o  out  32 (read data to core) / cpu_clk_en_o  out  1 (core advances only when 1) / cpu_stop_i  in  1 (core stop lamp).
REQ-005 SHALL have ports: mem_addr_o  out  5 / mem_we_o  out  1 / mem_wdata_o  out  32 / mem_rdata_i  in  32: 32x32 RAM with combinational read and write on the clock edge while mem_we_o=1.
REQ-006 SHALL have ports: host_req_i  in  1 (level, host wants the RAM) / host_start_i  in  1 (command pulse) / host_we_i  in  1 / host_addr_i  in  5.
REQ-007 SHALL have ports: host_byte_i  in  8 / host_valid_i  in  1 / host_ready_o  out  1 (write beats); host_byte_o  out  8 / host_valid_o  out  1 / host_ready_i  in  1 (read beats).
REQ-008 SHALL have ports: host_grant_o  out  1 / host_busy_o  out  1 / host_done_o  out  1 / halted_o  out  1.

Function
REQ-009 SHALL implement FSM states RUN, HALT, H_IDLE, H_LOAD, H_WRITE, H_SEND; all outputs decoded from registered state, beat counter (2 bit), latched address, latched direction and 32-bit shift register.
REQ-010 RUN: cpu_clk_en_o=1; mem_addr_o=cpu_addr_i, mem_we_o=cpu_rw_en_i, mem_wdata_o=cpu_data_i, cpu_data_o=mem_rdata_i.
REQ-011 RUN transitions, priority order: host_req_i=1 -> H_IDLE; else cpu_stop_i=1 -> HALT; else stay; the sampling cycle still has cpu_clk_en_o=1.
REQ-012 HALT: cpu_clk_en_o=0, mem_we_o=0, halted_o=1; host_req_i=1 -> H_IDLE.
REQ-013 H_IDLE: cpu_clk_en_o=0, mem_we_o=0, host_grant_o=1; host_req_i=0 -> RUN; else host_start_i=1 latches host_addr_i, host_we_i, clears beat counter; we=1 -> H_LOAD, we=0 -> H_SEND with shift register loaded from mem_rdata_i at latched-address read (mem_addr_o=host_addr_i combinationally during start cycle).
REQ-014 In all H_* states except H_IDLE mem_addr_o SHALL equal the latched address and cpu_data_o SHALL hold 0.
REQ-015 H_LOAD: host_ready_o=1; each cycle with host_valid_i=1 stores host_byte_i into bits [8k+7:8k], k = beat counter (byte 0 = LSB), increments k; on the 4th accepted beat -> H_WRITE.
REQ-016 H_WRITE: exactly one cycle, mem_we_o=1, mem_wdata_o=assembled word, host_done_o=1; -> H_IDLE.
REQ-017 H_SEND: host_valid_o=1, host_byte_o=byte k of shift register; advance k when host_ready_i=1; 4th accepted beat asserts host_done_o that cycle -> H_IDLE.
REQ-018 host_busy_o=1 in H_LOAD, H_WRITE, H_SEND; host_ready_o, host_valid_o, host_done_o SHALL be 0 in all other states.
REQ-019 host_req_i deassertion during a busy state SHALL be ignored until return to H_IDLE; host_start_i outside H_IDLE SHALL be ignored.
REQ-020 Write latency: start edge to RAM write edge = 4 accepted beats + 1 cycle (minimum 5 cycles); read: first byte valid cycle after start.
REQ-021 Returning to RUN with cpu_stop_i still 1 SHALL re-enter HALT after one RUN cycle.

Reset
REQ-022 reset_ni=0 SHALL immediately force state RUN, beat counter 0, shift register 0, latched address 0, independent of clock.
REQ-023 Reset values: cpu_clk_en_o=1, halted_o=0, host_grant_o=0, host_busy_o=0, host_done_o=0, host_ready_o=0, host_valid_o=0, host_byte_o=0; mem_* follow cpu_* per REQ-010.
REQ-024 Reset mid-transaction SHALL abandon it with no RAM write issued.

Verification
REQ-025 After reset, cpu_addr_i=5, cpu_rw_en_i=1, cpu_data_i=0xDEADBEEF -> mem_addr_o=5, mem_we_o=1, mem_wdata_o=0xDEADBEEF, cpu_clk_en_o=1.
REQ-026 host_req_i=1, start we=1 addr=0x1F, bytes 0x78,0x56,0x34,0x12 with a 2-cycle valid gap -> single H_WRITE cycle, mem_wdata_o=0x12345678, addr 0x1F, host_done_o one cycle.
REQ-027 RAM word 3=0xCAFEF00D, start we=0 addr=3, host_ready_i toggling 1/0 -> host_byte_o 0x0D,0xF0,0xFE,0xCA in order, done on 4th accept.
REQ-028 cpu_stop_i=1 in RUN -> HALT next cycle, cpu_clk_en_o=0, halted_o=1; host_req_i 1 then 0 -> RUN one cycle then HALT again.
REQ-029 host_req_i dropped after 2 write beats -> remains H_LOAD; completes on beats 3-4, then H_IDLE -> RUN next cycle.
REQ-030 reset_ni pulsed low after 3 write beats -> no mem_we_o pulse, state RUN, cpu_clk_en_o=1 without clock edge.

Source files
------------

// File: rtl/baby_ram_arbiter.sv
// baby_ram_arbiter
//   Shares a single 32x32 RAM between the Baby core and a byte-wide host port.
//   While the core runs, it owns the RAM and the arbiter only passes its
//   requests through. When the host asks for the RAM, the core clock is gated
//   and the host can move whole 32-bit words as four byte beats, LSB first.
//
// Ports
//   clock, reset_ni                 : clock, asynchronous active-low reset
//   cpu_addr_i/rw_en_i/data_i       : core memory request
//   cpu_data_o, cpu_clk_en_o        : core read data, core clock enable
//   cpu_stop_i                      : core stop lamp (enter HALT)
//   mem_addr_o/we_o/wdata_o/rdata_i : RAM port (combinational read)
//   host_req_i/start_i/we_i/addr_i  : host ownership level and command
//   host_byte_i/valid_i, ready_o    : host write beats into the arbiter
//   host_byte_o/valid_o, ready_i    : read beats out to the host
//   host_grant_o/busy_o/done_o      : host status
//   halted_o                        : core halted by its stop lamp
module baby_ram_arbiter (
    input  logic        clock,
    input  logic        reset_ni,
    input  logic [4:0]  cpu_addr_i,
    input  logic        cpu_rw_en_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_clk_en_o,
    input  logic        cpu_stop_i,
    output logic [4:0]  mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        host_req_i,
    input  logic        host_start_i,
    input  logic        host_we_i,
    input  logic [4:0]  host_addr_i,
    input  logic [7:0]  host_byte_i,
    input  logic        host_valid_i,
    output logic        host_ready_o,
    output logic [7:0]  host_byte_o,
    output logic        host_valid_o,
    input  logic        host_ready_i,
    output logic        host_grant_o,
    output logic        host_busy_o,
    output logic        host_done_o,
    output logic        halted_o
);

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_HALT    = 3'd1;
    localparam logic [2:0] S_H_IDLE  = 3'd2;
    localparam logic [2:0] S_H_LOAD  = 3'd3;
    localparam logic [2:0] S_H_WRITE = 3'd4;
    localparam logic [2:0] S_H_SEND  = 3'd5;

    logic [2:0]  r_state;
    logic [1:0]  r_beat;
    logic [4:0]  r_addr;
    logic        r_we;
    logic [31:0] r_shift;

    logic [7:0]  w_cur_byte;
    logic        w_last_beat;

    // Byte k of the word, byte 0 in the least significant bits.
    assign w_cur_byte  = r_shift[{r_beat, 3'b000} +: 8];
    assign w_last_beat = (r_beat == 2'd3);

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_RUN;
            r_beat  <= 2'd0;
            r_addr  <= 5'd0;
            r_we    <= 1'b0;
            r_shift <= 32'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (host_req_i)      r_state <= S_H_IDLE;
                    else if (cpu_stop_i) r_state <= S_HALT;
                end
                S_HALT: begin
                    if (host_req_i) r_state <= S_H_IDLE;
                end
                S_H_IDLE: begin
                    if (!host_req_i) begin
                        r_state <= S_RUN;
                    end else if (host_start_i) begin
                        r_addr <= host_addr_i;
                        r_we   <= host_we_i;
                        r_beat <= 2'd0;
                        if (host_we_i) begin
                            r_state <= S_H_LOAD;
                        end else begin
                            // mem_addr_o already shows host_addr_i this cycle,
                            // so the read word is captured on the start edge.
                            r_shift <= mem_rdata_i;
                            r_state <= S_H_SEND;
                        end
                    end
                end
                S_H_LOAD: begin
                    if (host_valid_i) begin
                        r_shift[{r_beat, 3'b000} +: 8] <= host_byte_i;
                        r_beat <= r_beat + 2'd1;
                        if (w_last_beat) r_state <= S_H_WRITE;
                    end
                end
                S_H_WRITE: begin
                    r_state <= S_H_IDLE;
                end
                S_H_SEND: begin
                    if (host_ready_i) begin
                        r_beat <= r_beat + 2'd1;
                        if (w_last_beat) r_state <= S_H_IDLE;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    always_comb begin
        cpu_data_o   = 32'd0;
        cpu_clk_en_o = 1'b0;
        mem_addr_o   = r_addr;
        mem_we_o     = 1'b0;
        mem_wdata_o  = r_shift;
        host_ready_o = 1'b0;
        host_byte_o  = 8'd0;
        host_valid_o = 1'b0;
        host_grant_o = 1'b0;
        host_busy_o  = 1'b0;
        host_done_o  = 1'b0;
        halted_o     = 1'b0;
        case (r_state)
            S_RUN: begin
                cpu_clk_en_o = 1'b1;
                mem_addr_o   = cpu_addr_i;
                mem_we_o     = cpu_rw_en_i;
                mem_wdata_o  = cpu_data_i;
                cpu_data_o   = mem_rdata_i;
            end
            S_HALT: begin
                halted_o   = 1'b1;
                mem_addr_o = cpu_addr_i;
            end
            S_H_IDLE: begin
                host_grant_o = 1'b1;
                if (host_start_i) mem_addr_o = host_addr_i;
            end
            S_H_LOAD: begin
                host_busy_o  = 1'b1;
                host_ready_o = 1'b1;
            end
            S_H_WRITE: begin
                host_busy_o = 1'b1;
                mem_we_o    = r_we;
                host_done_o = 1'b1;
            end
            S_H_SEND: begin
                host_busy_o  = 1'b1;
                host_valid_o = 1'b1;
                host_byte_o  = w_cur_byte;
                host_done_o  = host_ready_i & w_last_beat;
            end
            default: begin
                cpu_clk_en_o = 1'b1;
                mem_addr_o   = cpu_addr_i;
            end
        endcase
    end

endmodule

// File: tb/tb_baby_ram_arbiter.sv
module tb_baby_ram_arbiter;
    logic        clock = 1'b0;
    logic        reset_ni;
    logic [4:0]  cpu_addr;
    logic        cpu_rw_en;
    logic [31:0] cpu_data_in;
    logic [31:0] cpu_data_out;
    logic        cpu_clk_en;
    logic        cpu_stop;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        host_req, host_start, host_we;
    logic [4:0]  host_addr;
    logic [7:0]  host_byte_in;
    logic        host_valid_in, host_ready_out;
    logic [7:0]  host_byte_out;
    logic        host_valid_out, host_ready_in;
    logic        host_grant, host_busy, host_done, halted;

    always #5 clock = ~clock;

    baby_ram_arbiter dut (
        .clock(clock), .reset_ni(reset_ni),
        .cpu_addr_i(cpu_addr), .cpu_rw_en_i(cpu_rw_en), .cpu_data_i(cpu_data_in),
        .cpu_data_o(cpu_data_out), .cpu_clk_en_o(cpu_clk_en), .cpu_stop_i(cpu_stop),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .host_req_i(host_req), .host_start_i(host_start), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_byte_i(host_byte_in), .host_valid_i(host_valid_in), .host_ready_o(host_ready_out),
        .host_byte_o(host_byte_out), .host_valid_o(host_valid_out), .host_ready_i(host_ready_in),
        .host_grant_o(host_grant), .host_busy_o(host_busy), .host_done_o(host_done), .halted_o(halted)
    );

    // RAM model: combinational read, write on the clock edge.
    logic [31:0] ram [32];
    logic        tb_clr;
    assign mem_rdata = ram[mem_addr];
    always @(posedge clock) begin
        if (tb_clr) begin
            for (int i = 0; i < 32; i++) ram[i] <= 32'd0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: host writes {addr,data}, read beats {last,byte}.
    logic [36:0] exp_wr_q [$];
    logic [8:0]  exp_rd_q [$];
    logic [36:0] wr_e;
    logic [8:0]  rd_e;
    int          host_wr_pulses = 0;

    always @(negedge clock) begin
        if (reset_ni) begin
            // Any RAM write while the core is gated belongs to the host.
            if (mem_we && !cpu_clk_en) begin
                host_wr_pulses++;
                if (exp_wr_q.size() == 0) begin
                    chk("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    wr_e = exp_wr_q.pop_front();
                    chk("wr_addr", {27'd0, mem_addr}, {27'd0, wr_e[36:32]});
                    chk("wr_data", mem_wdata, wr_e[31:0]);
                    chk("wr_done", {31'd0, host_done}, 32'd1);
                end
            end
            if (host_valid_out && host_ready_in) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    rd_e = exp_rd_q.pop_front();
                    chk("rd_byte", {24'd0, host_byte_out}, {24'd0, rd_e[7:0]});
                    chk("rd_done", {31'd0, host_done}, {31'd0, rd_e[8]});
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue a host write command and deliver nbeats bytes with gap idle
    // cycles between beats; host_req drops after beat drop_after.
    task automatic host_write(input logic [4:0] a, input logic [31:0] d, input int gap,
                              input int drop_after, input int nbeats, input bit expect_wr);
        host_addr = a; host_we = 1'b1; host_start = 1'b1;
        if (expect_wr) exp_wr_q.push_back({a, d});
        step();
        host_start = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            host_byte_in = d[8*k +: 8];
            host_valid_in = 1'b1;
            @(negedge clock);
            chk("ld_ready", {31'd0, host_ready_out}, 32'd1);
            chk("ld_addr", {27'd0, mem_addr}, {27'd0, a});
            chk("ld_cpu_data", cpu_data_out, 32'd0);
            step();
            host_valid_in = 1'b0;
            host_byte_in = 8'd0;
            if (k + 1 == drop_after) host_req = 1'b0;
            if (k < nbeats - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clock);
                    chk("ld_gap_busy", {31'd0, host_busy}, 32'd1);
                    step();
                end
            end
        end
    endtask

    int wr_before;

    initial begin
        reset_ni = 1'b0; tb_clr = 1'b1;
        cpu_addr = 5'd0; cpu_rw_en = 1'b0; cpu_data_in = 32'd0; cpu_stop = 1'b0;
        host_req = 1'b0; host_start = 1'b0; host_we = 1'b0; host_addr = 5'd0;
        host_byte_in = 8'd0; host_valid_in = 1'b0; host_ready_in = 1'b0;

        // Reset values before any clock edge.
        #2;
        chk("rst_clk_en", {31'd0, cpu_clk_en}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_grant", {31'd0, host_grant}, 32'd0);
        chk("rst_busy", {31'd0, host_busy}, 32'd0);
        chk("rst_done", {31'd0, host_done}, 32'd0);
        chk("rst_ready", {31'd0, host_ready_out}, 32'd0);
        chk("rst_valid", {31'd0, host_valid_out}, 32'd0);
        chk("rst_byte", {24'd0, host_byte_out}, 32'd0);
        repeat (3) step();
        tb_clr = 1'b0;
        reset_ni = 1'b1;
        step();

        // Core pass-through write, then read back.
        cpu_addr = 5'd5; cpu_rw_en = 1'b1; cpu_data_in = 32'hDEADBEEF;
        @(negedge clock);
        chk("run_addr", {27'd0, mem_addr}, 32'd5);
        chk("run_we", {31'd0, mem_we}, 32'd1);
        chk("run_wdata", mem_wdata, 32'hDEADBEEF);
        chk("run_clk_en", {31'd0, cpu_clk_en}, 32'd1);
        step();
        cpu_rw_en = 1'b0;
        @(negedge clock);
        chk("run_rdata", cpu_data_out, 32'hDEADBEEF);
        step();

        // Host write with 2-cycle gaps between beats.
        host_req = 1'b1;
        @(negedge clock);
        chk("req_sample_clk_en", {31'd0, cpu_clk_en}, 32'd1);
        step();
        @(negedge clock);
        chk("idle_grant", {31'd0, host_grant}, 32'd1);
        chk("idle_clk_en", {31'd0, cpu_clk_en}, 32'd0);
        step();
        host_write(5'h1F, 32'h12345678, 2, 0, 4, 1'b1);
        step();
        @(negedge clock);
        chk("wr_q_empty", exp_wr_q.size(), 32'd0);
        chk("wr_back_idle", {31'd0, host_grant}, 32'd1);
        chk("wr_done_once", {31'd0, host_done}, 32'd0);
        chk("wr_ram", ram[5'h1F], 32'h12345678);

        // Host read of word 3 with host_ready toggling.
        host_req = 1'b0;
        step();
        cpu_addr = 5'd3; cpu_rw_en = 1'b1; cpu_data_in = 32'hCAFEF00D;
        step();
        cpu_rw_en = 1'b0; host_req = 1'b1;
        step();
        host_addr = 5'd3; host_we = 1'b0; host_start = 1'b1;
        exp_rd_q.push_back({1'b0, 8'h0D});
        exp_rd_q.push_back({1'b0, 8'hF0});
        exp_rd_q.push_back({1'b0, 8'hFE});
        exp_rd_q.push_back({1'b1, 8'hCA});
        step();
        host_start = 1'b0;
        host_ready_in = 1'b1;
        @(negedge clock);
        chk("rd_first_valid", {31'd0, host_valid_out}, 32'd1);
        chk("rd_addr", {27'd0, mem_addr}, 32'd3);
        chk("rd_cpu_data", cpu_data_out, 32'd0);
        step();
        for (int c = 1; c < 40 && exp_rd_q.size() != 0; c++) begin
            host_ready_in = (c % 2 == 0);
            @(negedge clock);
            step();
        end
        host_ready_in = 1'b0;
        chk("rd_q_empty", exp_rd_q.size(), 32'd0);
        @(negedge clock);
        chk("rd_back_idle", {31'd0, host_grant & ~host_busy}, 32'd1);
        chk("rd_valid_off", {31'd0, host_valid_out}, 32'd0);

        // Stop lamp and host override of HALT.
        host_req = 1'b0;
        step();
        cpu_stop = 1'b1;
        @(negedge clock);
        chk("stop_sample_clk_en", {31'd0, cpu_clk_en}, 32'd1);
        step();
        cpu_rw_en = 1'b1;
        @(negedge clock);
        chk("halt_clk_en", {31'd0, cpu_clk_en}, 32'd0);
        chk("halt_lamp", {31'd0, halted}, 32'd1);
        chk("halt_we", {31'd0, mem_we}, 32'd0);
        cpu_rw_en = 1'b0;
        host_req = 1'b1;
        step();
        @(negedge clock);
        chk("halt_to_idle", {31'd0, host_grant}, 32'd1);
        host_req = 1'b0;
        step();
        @(negedge clock);
        chk("rerun_clk_en", {31'd0, cpu_clk_en}, 32'd1);
        chk("rerun_halted", {31'd0, halted}, 32'd0);
        step();
        @(negedge clock);
        chk("rehalt", {31'd0, halted}, 32'd1);
        cpu_stop = 1'b0;
        host_req = 1'b1;
        step();
        host_req = 1'b0;
        step();
        @(negedge clock);
        chk("resume_run", {31'd0, cpu_clk_en}, 32'd1);

        // host_req dropped after two beats is ignored until H_IDLE.
        host_req = 1'b1;
        step();
        host_write(5'h0A, 32'hA5A50F0F, 1, 2, 4, 1'b1);
        step();
        @(negedge clock);
        chk("drop_idle", {31'd0, host_grant}, 32'd1);
        chk("drop_wr_q_empty", exp_wr_q.size(), 32'd0);
        step();
        @(negedge clock);
        chk("drop_run", {31'd0, cpu_clk_en}, 32'd1);
        chk("drop_grant_off", {31'd0, host_grant}, 32'd0);
        step();

        // Reset after three beats abandons the write.
        wr_before = host_wr_pulses;
        host_req = 1'b1;
        step();
        host_write(5'h07, 32'h11223344, 0, 0, 3, 1'b0);
        #2;
        reset_ni = 1'b0;
        host_req = 1'b0;
        #1;
        chk("arst_clk_en", {31'd0, cpu_clk_en}, 32'd1);
        chk("arst_busy", {31'd0, host_busy}, 32'd0);
        chk("arst_ready", {31'd0, host_ready_out}, 32'd0);
        chk("arst_grant", {31'd0, host_grant}, 32'd0);
        chk("arst_we", {31'd0, mem_we}, 32'd0);
        repeat (2) step();
        reset_ni = 1'b1;
        repeat (3) step();
        @(negedge clock);
        chk("arst_no_write", host_wr_pulses - wr_before, 32'd0);
        chk("arst_ram", ram[5'h07], 32'd0);
        chk("arst_run_addr", {27'd0, mem_addr}, {27'd0, cpu_addr});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
